// File: rtl/sp_instr_ram_loader_if.sv
// Bus bundle between the instruction RAM loader and its neighbours:
// the incoming boot/debug word stream and the single-port RAM wrapper port.
interface sp_instr_ram_loader_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) ();
    // word stream (valid/ready)
    logic                    data_valid;
    logic [DATA_WIDTH-1:0]   data;
    logic                    data_ready;

    // single-port RAM wrapper port, read data one cycle after a read enable
    logic                    ram_en;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic                    ram_we;
    logic [DATA_WIDTH/8-1:0] ram_be;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    // loader side
    modport master (
        input  data_valid, data, ram_rdata,
        output data_ready, ram_en, ram_addr, ram_wdata, ram_we, ram_be
    );

    // stream source / RAM wrapper side
    modport slave (
        output data_valid, data, ram_rdata,
        input  data_ready, ram_en, ram_addr, ram_wdata, ram_we, ram_be
    );
endinterface

// File: rtl/sp_instr_ram_loader.sv
// Instruction RAM loader: streams N words into the RAM from a base address,
// reads the region back and compares write/read sums, then pulses done.
// The core is held off for the whole load.
module sp_instr_ram_loader #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-2:0] num_words_i,
    sp_instr_ram_loader_if.master bus,
    output logic                  core_hold_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [DATA_WIDTH-1:0] checksum_o
);
    localparam logic [ADDR_WIDTH-2:0] MAX_WORDS = (ADDR_WIDTH-1)'(RAM_SIZE / 4);
    localparam logic [ADDR_WIDTH-2:0] ONE_W     = (ADDR_WIDTH-1)'(1);

    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, DRAIN, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   base_reg, base_next;
    logic [ADDR_WIDTH-2:0]   count_reg, count_next;
    logic [ADDR_WIDTH-2:0]   idx_reg, idx_next;
    logic [DATA_WIDTH-1:0]   wsum_reg, wsum_next;
    logic [DATA_WIDTH-1:0]   rsum_reg, rsum_next;
    logic                    rd_pending_reg, rd_pending_next;
    logic                    error_reg, error_next;
    logic [DATA_WIDTH-1:0]   checksum_reg, checksum_next;

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-2:0]   last_idx;
    logic [ADDR_WIDTH-2:0]   n_clamped;
    logic                    write_beat;

    // word index to byte address, wrapping modulo the address space
    assign cur_addr  = base_reg + ADDR_WIDTH'({idx_reg, 2'b00});
    assign last_idx  = count_reg - ONE_W;
    assign n_clamped = (num_words_i > MAX_WORDS) ? MAX_WORDS : num_words_i;

    // all byte lanes are written on a write beat, none on a read
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_be
            assign bus.ram_be[gi] = write_beat;
        end
    endgenerate

    // state and datapath registers, synchronous reset aborts any run
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            count_reg      <= '0;
            idx_reg        <= '0;
            wsum_reg       <= '0;
            rsum_reg       <= '0;
            rd_pending_reg <= 1'b0;
            error_reg      <= 1'b0;
            checksum_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            count_reg      <= count_next;
            idx_reg        <= idx_next;
            wsum_reg       <= wsum_next;
            rsum_reg       <= rsum_next;
            rd_pending_reg <= rd_pending_next;
            error_reg      <= error_next;
            checksum_reg   <= checksum_next;
        end
    end

    // next-state logic and bus/status outputs
    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        count_next      = count_reg;
        idx_next        = idx_reg;
        wsum_next       = wsum_reg;
        // read data arrives one cycle after each read enable
        rsum_next       = rd_pending_reg ? (rsum_reg + bus.ram_rdata) : rsum_reg;
        rd_pending_next = 1'b0;
        error_next      = error_reg;
        checksum_next   = checksum_reg;
        bus.data_ready  = 1'b0;
        bus.ram_en      = 1'b0;
        bus.ram_we      = 1'b0;
        bus.ram_addr    = '0;
        bus.ram_wdata   = '0;
        write_beat      = 1'b0;
        core_hold_o     = 1'b1;
        done_o          = 1'b0;
        error_o         = error_reg;
        checksum_o      = checksum_reg;

        unique case (state_reg)
            IDLE: begin
                core_hold_o = 1'b0;
                if (start_i) begin
                    base_next     = base_addr_i & ~ADDR_WIDTH'(3);
                    count_next    = n_clamped;
                    idx_next      = '0;
                    wsum_next     = '0;
                    rsum_next     = '0;
                    error_next    = 1'b0;
                    checksum_next = '0;
                    state_next    = (n_clamped == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                bus.data_ready = 1'b1;
                if (bus.data_valid) begin
                    bus.ram_en    = 1'b1;
                    bus.ram_we    = 1'b1;
                    write_beat    = 1'b1;
                    bus.ram_addr  = cur_addr;
                    bus.ram_wdata = bus.data;
                    wsum_next     = wsum_reg + bus.data;
                    if (idx_reg == last_idx) begin
                        idx_next   = '0;
                        state_next = VERIFY;
                    end else begin
                        idx_next = idx_reg + ONE_W;
                    end
                end
            end
            VERIFY: begin
                bus.ram_en      = 1'b1;
                bus.ram_addr    = cur_addr;
                rd_pending_next = 1'b1;
                if (idx_reg == last_idx) begin
                    idx_next   = '0;
                    state_next = DRAIN;
                end else begin
                    idx_next = idx_reg + ONE_W;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                done_o        = 1'b1;
                error_o       = (wsum_reg != rsum_reg);
                checksum_o    = wsum_reg;
                error_next    = (wsum_reg != rsum_reg);
                checksum_next = wsum_reg;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_sp_instr_ram_loader.sv
// Bench for the instruction RAM loader: a RAM model answers the bus, and a
// phase-level model (write beats, then N reads, drain, done) predicts every
// output on every cycle of each run.
module tb_sp_instr_ram_loader;
    localparam int AW   = 15;
    localparam int DW   = 32;
    localparam int MAXW = 8192;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [AW-2:0] num_words_i;
    logic          core_hold_o;
    logic          done_o;
    logic          error_o;
    logic [DW-1:0] checksum_o;

    sp_instr_ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sp_instr_ram_loader #(.RAM_SIZE(32768), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .num_words_i (num_words_i),
        .bus         (bus),
        .core_hold_o (core_hold_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .checksum_o  (checksum_o)
    );

    always #5 clk = ~clk;

    // RAM model with one-cycle read latency and optional read corruption
    logic [DW-1:0] mem [0:MAXW-1];
    bit            corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we)
                mem[bus.ram_addr[AW-1:2]] <= bus.ram_wdata;
            else
                bus.ram_rdata <= mem[bus.ram_addr[AW-1:2]] ^
                                 ((corrupt_en && bus.ram_addr == corrupt_addr) ? 32'h1 : 32'h0);
        end
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    logic          prev_err = 1'b0;
    logic [DW-1:0] prev_sum = '0;
    int            obs_done;
    logic [DW-1:0] obs_sum;
    logic [AW-1:0] obs_wr[$];
    int            obs_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},    32'(bus.data_ready), 0);
        chk({tag, "_en"},       32'(bus.ram_en), 0);
        chk({tag, "_we"},       32'(bus.ram_we), 0);
        chk({tag, "_be"},       32'(bus.ram_be), 0);
        chk({tag, "_addr"},     32'(bus.ram_addr), 0);
        chk({tag, "_wdata"},    bus.ram_wdata, 0);
        chk({tag, "_hold"},     32'(core_hold_o), 0);
        chk({tag, "_done"},     32'(done_o), 0);
        chk({tag, "_error"},    32'(error_o), 0);
        chk({tag, "_checksum"}, checksum_o, 0);
    endtask

    // One load: vmode 0 = continuous valid, 1 = 1,0,1,0..., 2 = random.
    // abort_at / restart_at give the cycle for a reset or a stray start (-1 = none).
    task automatic run(input logic [AW-1:0] base, input logic [AW-2:0] num, input int vmode,
                       input bit seq, input bit corrupt, input int abort_at, input int restart_at);
        int            n, sent, wr_end, k;
        logic [DW-1:0] words[$];
        logic [DW-1:0] sum, w, ex_wd;
        logic [AW-1:0] ba, ex_addr;
        bit            v, in_write, exp_err, ex_en, ex_we, ex_rdy, ex_done;

        n   = (int'(num) > MAXW) ? MAXW : int'(num);
        ba  = {base[AW-1:2], 2'b00};
        sum = '0;
        for (int i = 0; i < n; i++) begin
            w = seq ? 32'(i + 1) : $urandom;
            words.push_back(w);
            sum += w;
        end
        exp_err      = corrupt && (n >= 2);
        corrupt_en   = corrupt;
        corrupt_addr = ba + AW'(4);
        obs_done     = -1;
        obs_sum      = '0;
        obs_wr.delete();
        obs_acc      = 0;

        // cycle 0: start offered while idle, previous results still visible
        @(posedge clk); #1;
        cyc = 0;
        start_i = 1'b1; base_addr_i = base; num_words_i = num;
        bus.data_valid = 1'($urandom % 2); bus.data = $urandom;
        @(negedge clk);
        chk("idle_hold", 32'(core_hold_o), 0);
        chk("idle_en", 32'(bus.ram_en), 0);
        chk("idle_ready", 32'(bus.data_ready), 0);
        chk("idle_done", 32'(done_o), 0);
        chk("idle_error", 32'(error_o), 32'(prev_err));
        chk("idle_checksum", checksum_o, prev_sum);

        sent   = 0;
        wr_end = -1;
        for (k = 1; k < 60000; k++) begin
            @(posedge clk); #1;
            cyc = k;
            start_i = (k == restart_at);
            if (k == restart_at) begin
                base_addr_i = AW'($urandom);
                num_words_i = (AW-1)'($urandom);
            end
            rst_i = (k == abort_at);
            in_write = (sent < n);
            if (in_write)
                v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((k - 1) % 2 == 0) : ($urandom % 100 < 60);
            else
                v = 1'($urandom % 2);
            bus.data_valid = v;
            bus.data = (in_write && v) ? words[sent] : $urandom;

            ex_rdy = 0; ex_en = 0; ex_we = 0; ex_done = 0; ex_addr = '0; ex_wd = '0;
            if (in_write) begin
                ex_rdy = 1; ex_en = v; ex_we = v;
                ex_addr = ba + AW'(4 * sent);
                ex_wd = words[sent];
            end else if (k <= wr_end + n) begin
                ex_en = 1;
                ex_addr = ba + AW'(4 * (k - wr_end - 1));
            end else if (k == wr_end + n + 2) begin
                ex_done = 1;
            end

            @(negedge clk);
            chk("ready", 32'(bus.data_ready), 32'(ex_rdy));
            chk("hold", 32'(core_hold_o), 1);
            chk("done", 32'(done_o), 32'(ex_done));
            chk("ram_en", 32'(bus.ram_en), 32'(ex_en));
            if (ex_en) begin
                chk("ram_we", 32'(bus.ram_we), 32'(ex_we));
                chk("ram_addr", 32'(bus.ram_addr), 32'(ex_addr));
                chk("ram_be", 32'(bus.ram_be), ex_we ? 32'hF : 32'h0);
                if (ex_we) chk("ram_wdata", bus.ram_wdata, ex_wd);
            end
            chk("error", 32'(error_o), ex_done ? 32'(exp_err) : 32'h0);
            chk("checksum", checksum_o, ex_done ? sum : 32'h0);

            if (bus.ram_en && bus.ram_we) obs_wr.push_back(bus.ram_addr);
            if (bus.ram_en) obs_acc++;
            if (done_o && obs_done < 0) begin
                obs_done = k;
                obs_sum = checksum_o;
            end

            if (in_write && v) begin
                sent++;
                if (sent == n) wr_end = k;
            end

            if (k == abort_at) begin
                @(posedge clk); #1;
                cyc = k + 1;
                rst_i = 1'b0;
                start_i = 1'b0;
                bus.data_valid = 1'($urandom % 2);
                @(negedge clk);
                chk_all_zero("after_reset");
                prev_err = 1'b0;
                prev_sum = '0;
                return;
            end
            if (ex_done) break;
        end
        if (k >= 60000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: no completion within cycle budget, got none expected done");
        end
        prev_err = exp_err;
        prev_sum = sum;

        // trailing idle cycle: results hold, core released
        @(posedge clk); #1;
        cyc = k + 1;
        start_i = 1'b0;
        bus.data_valid = 1'($urandom % 2);
        @(negedge clk);
        chk("post_hold", 32'(core_hold_o), 0);
        chk("post_en", 32'(bus.ram_en), 0);
        chk("post_done", 32'(done_o), 0);
        chk("post_error", 32'(error_o), 32'(prev_err));
        chk("post_checksum", checksum_o, prev_sum);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
        bus.data_valid = 1'b0; bus.data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_i = 1'b0;

        // basic load of 1,2,3,4
        run(15'h100, 14'd4, 0, 1, 0, -1, -1);
        chk("tp1_done_cycle", 32'(obs_done), 10);
        chk("tp1_checksum", obs_sum, 10);
        chk("tp1_wr0", 32'(obs_wr[0]), 32'h100);
        chk("tp1_wr3", 32'(obs_wr[3]), 32'h10C);

        // region wraps past the top of RAM
        run(15'h7FF8, 14'd4, 0, 0, 0, -1, -1);
        chk("wrap_wr0", 32'(obs_wr[0]), 32'h7FF8);
        chk("wrap_wr1", 32'(obs_wr[1]), 32'h7FFC);
        chk("wrap_wr2", 32'(obs_wr[2]), 32'h0000);
        chk("wrap_wr3", 32'(obs_wr[3]), 32'h0004);

        // gapped valid stream
        run(15'h2A3, 14'd3, 1, 0, 0, -1, -1);
        chk("gap_done_cycle", 32'(obs_done), 10);
        chk("gap_writes", 32'(obs_wr.size()), 3);

        // corrupted read-back, error sticky until next start
        run(15'h200, 14'd4, 0, 1, 1, -1, -1);
        chk("corrupt_error", 32'(error_o), 1);
        run(15'h400, 14'd2, 0, 0, 0, -1, -1);

        // zero-length load
        run(15'h40, 14'd0, 0, 0, 0, -1, -1);
        chk("zero_done_cycle", 32'(obs_done), 1);
        chk("zero_accesses", 32'(obs_acc), 0);
        chk("zero_checksum", obs_sum, 0);

        // reset in the third write cycle, then a normal run
        run(15'h100, 14'd8, 0, 0, 0, 3, -1);
        run(15'h180, 14'd5, 2, 0, 0, -1, -1);

        // stray start during verify is ignored
        run(15'h300, 14'd6, 0, 0, 0, -1, 9);

        // word count above RAM capacity is clamped
        run(AW'($urandom), 14'h3FFF, 0, 0, 0, -1, -1);
        chk("clamp_writes", 32'(obs_wr.size()), MAXW);

        // randomized loads
        for (int r = 0; r < 12; r++)
            run(AW'($urandom), 14'($urandom_range(0, 24)), $urandom_range(0, 2),
                0, 1'($urandom % 2), -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sp_instr_ram_loader.md
Name: sp_instr_ram_loader

Overview:
- Bus master for the single-port instruction RAM wrapper: drives its en/addr/wdata/we/be port and consumes its 1-cycle-latency read data.
- On start, accepts a word stream (valid/ready) and writes it sequentially into instruction RAM from a base address.
- Then reads the region back, compares a running sum of written words against a sum of read words, and reports done/error.
- Sits between the boot/debug stream source and the instruction RAM wrapper; holds the core off while busy.

Parameters:
- RAM_SIZE, 32768, instruction RAM size in bytes.
- ADDR_WIDTH, $clog2(RAM_SIZE), byte-address width.
- DATA_WIDTH, 32, word width (only 32 supported).

Ports:
- clk  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  start pulse; ignored unless IDLE
- base_addr_i  in  ADDR_WIDTH  byte base address, bits [1:0] ignored
- num_words_i  in  ADDR_WIDTH-1  word count, sampled on start
- data_valid_i  in  1  stream word valid
- data_i  in  DATA_WIDTH  stream word
- data_ready_o  out  1  stream ready
- ram_en_o  out  1  RAM enable
- ram_addr_o  out  ADDR_WIDTH  RAM byte address, [1:0]=0
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DATA_WIDTH/8  byte enables
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after a read enable
- core_hold_o  out  1  high while not IDLE
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky checksum mismatch, cleared on accepted start
- checksum_o  out  DATA_WIDTH  sum of written words, mod 2^32

Behaviour:
- Reset (rst_i on a clk edge) applies all of the following:
  - State returns to IDLE; counters and sums clear.
  - All outputs go to 0: data_ready_o, ram_*, core_hold_o, done_o, error_o, checksum_o.
  - rst_i mid-operation aborts immediately; no further RAM accesses start after that edge.
- States: IDLE, WRITE, VERIFY, DRAIN, DONE.
- IDLE:
  - ram_en_o=0.
  - On start_i, latch base (with [1:0] forced to 0) and count N = min(num_words_i, RAM_SIZE/4).
  - Clear sums, clear error_o, go to WRITE.
  - If N==0, go to DONE instead.
- WRITE:
  - data_ready_o=1.
  - Each beat with data_valid_i=1 drives, in that same cycle and combinationally from valid: ram_en_o=1, ram_we_o=1, ram_be_o=all ones, ram_addr_o=base+4*idx, ram_wdata_o=data_i.
  - On each beat: wsum+=data_i, idx++.
  - data_valid_i=0: no RAM access, no state change.
  - After beat N-1, idx clears and the state goes to VERIFY.
- VERIFY:
  - One read per cycle: ram_en_o=1, ram_we_o=0, ram_be_o=0, ram_addr_o=base+4*idx.
  - ram_rdata_i is sampled and added to rsum in the cycle after each read.
  - After read N-1, go to DRAIN.
- DRAIN: ram_en_o=0; accumulate the last read word; go to DONE.
- DONE, one cycle:
  - done_o=1, checksum_o=wsum, error_o=(wsum!=rsum).
  - Next state IDLE.
  - error_o and checksum_o hold until the next accepted start or reset.
- Address arithmetic is modulo 2^ADDR_WIDTH: the region wraps from RAM_SIZE-4 to 0.
- Timing with continuous valid, start at cycle 0:
  - WRITE cycles 1..N, VERIFY N+1..2N, DRAIN 2N+1, done_o at 2N+2.
  - N==0: done_o at cycle 1.
- start_i while not IDLE is ignored; latched parameters are unaffected.
- data_ready_o=0 outside WRITE; stream data offered then is not consumed.
- core_hold_o=1 in WRITE, VERIFY, DRAIN and DONE.

Test Plan:
- Base 0x100, N=4, words 1,2,3,4 continuous -> writes to 0x100..0x10C; reads 0x100..0x10C; done_o at cycle 10; checksum_o=10; error_o=0.
- Base 0x7FF8, N=4 -> write addresses 0x7FF8, 0x7FFC, 0x0000, 0x0004; reads follow the same order; error_o=0.
- N=3 with data_valid_i toggling 1,0,1,0,1 -> exactly 3 writes, none in gap cycles; done_o 2N+2+2 cycles after start.
- Model corrupts the read word at the second address (XOR 0x1) -> error_o=1 after done_o; stays 1 until the next start.
- N=0 -> no ram_en_o; done_o at cycle 1; checksum_o=0; error_o=0.
- rst_i asserted in the third WRITE cycle -> the next cycle has every output 0; a later start runs normally. start_i pulsed during VERIFY -> ignored, and the in-flight run completes unchanged.
